// File: rtl/gpio_ctrl_pkg.sv
// Shared constants and types for the GPIO mux-bank configuration controller.
package gpio_ctrl_pkg;

  localparam int unsigned PINCFG_BASE = 32'h00;
  localparam int unsigned IRQEN_A     = 32'h18;
  localparam int unsigned IRQPOL_A    = 32'h19;
  localparam int unsigned IRQPEND_A   = 32'h1A;
  localparam int unsigned CTRL_A      = 32'h1B;

  localparam int unsigned FIELD_W     = 2;
  localparam int unsigned MOD_LSB     = 0;
  localparam int unsigned SEL_LSB     = 2;
  localparam int unsigned PINCFG_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/gpio_irq_latch.sv
// One-bit interrupt pending latch: rising-edge detect on intr, clear pulse loses to a new edge.
module gpio_irq_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic intr,
  input  logic clr,
  output logic pend
);

  logic intr_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_prev <= 1'b0;
      pend      <= 1'b0;
    end else begin
      intr_prev <= intr;
      if (intr && !intr_prev) begin
        pend <= 1'b1;
      end else if (clr) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gpio_cfg_ctrl.sv
// Register-mapped pin mux configuration and interrupt controller for the GPIO bank.
module gpio_cfg_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int unsigned NPINS = 24,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [AW-1:0]      req_addr,
  input  logic [DW-1:0]      req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [2*NPINS-1:0] mod_all,
  output logic [2*NPINS-1:0] sel_all,
  output logic [NPINS-1:0]   irqen,
  output logic [NPINS-1:0]   irqpol,
  output logic [NPINS-1:0]   irqres,
  input  logic [NPINS-1:0]   intr,
  output logic               irq
);

  state_e                state_q, state_d;
  logic                  accept_c;
  logic                  we_q;
  logic [AW-1:0]         addr_q;
  logic [DW-1:0]         wdata_q;
  logic                  en_q;
  logic [NPINS-1:0]      pend;
  logic [31:0]           addr_c, pin_c;
  logic                  is_pin_c, err_c, write_c;
  logic [PINCFG_W-1:0]   pincfg_c;
  logic [DW-1:0]         rdata_c;
  logic                  unused_c;

  assign unused_c = ^wdata_q;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept_c = 1'b1;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Address decode and read mux for the captured request
  always_comb begin
    addr_c   = 32'(addr_q);
    pin_c    = addr_c - PINCFG_BASE;
    is_pin_c = (pin_c < NPINS) && (addr_c < IRQEN_A);
    err_c    = !is_pin_c && ((addr_c < IRQEN_A) || (addr_c > CTRL_A));
    write_c  = (state_q == ST_ACCESS) && we_q && !err_c;
    pincfg_c = '0;
    for (int unsigned i = 0; i < NPINS; i++) begin
      if (is_pin_c && (pin_c == i)) begin
        pincfg_c[SEL_LSB +: FIELD_W] = sel_all[2*i +: FIELD_W];
        pincfg_c[MOD_LSB +: FIELD_W] = mod_all[2*i +: FIELD_W];
      end
    end
    case (addr_c)
      IRQEN_A:   rdata_c = DW'(irqen);
      IRQPOL_A:  rdata_c = DW'(irqpol);
      IRQPEND_A: rdata_c = DW'(pend);
      CTRL_A:    rdata_c = DW'(en_q);
      default:   rdata_c = is_pin_c ? DW'(pincfg_c) : '0;
    endcase
  end

  // FSM state, request capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_ready <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      irqres    <= '0;
      irq       <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == ST_IDLE);
      irqres    <= '0;
      if (accept_c) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        // Clear pulse lines up with the ACCESS cycle that applies the W1C
        if (req_we && (32'(req_addr) == IRQPEND_A)) begin
          irqres <= req_wdata[NPINS-1:0];
        end
      end
      if (state_q == ST_ACCESS) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err_c;
        rsp_rdata <= we_q ? '0 : rdata_c;
      end else if ((state_q == ST_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
      irq <= en_q & (|(pend & irqen));
    end
  end

  // Configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_all <= '0;
      sel_all <= '0;
      irqen   <= '0;
      irqpol  <= '0;
      en_q    <= 1'b0;
    end else if (write_c) begin
      for (int unsigned i = 0; i < NPINS; i++) begin
        if (is_pin_c && (pin_c == i)) begin
          mod_all[2*i +: FIELD_W] <= wdata_q[MOD_LSB +: FIELD_W];
          sel_all[2*i +: FIELD_W] <= wdata_q[SEL_LSB +: FIELD_W];
        end
      end
      case (addr_c)
        IRQEN_A:  irqen  <= wdata_q[NPINS-1:0];
        IRQPOL_A: irqpol <= wdata_q[NPINS-1:0];
        CTRL_A:   en_q   <= wdata_q[0];
        default:  ;
      endcase
    end
  end

  for (genvar g = 0; g < NPINS; g++) begin : g_irq
    gpio_irq_latch u_latch (
      .clk   (clk),
      .rst_n (rst_n),
      .intr  (intr[g]),
      .clr   (irqres[g]),
      .pend  (pend[g])
    );
  end

endmodule

// File: tb/tb_gpio_cfg_ctrl.sv
// Scoreboard bench for gpio_cfg_ctrl: bus transactions, config outputs and interrupt flow.
module tb_gpio_cfg_ctrl;

  localparam int unsigned NPINS = 24;
  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid, req_ready, req_we;
  logic [AW-1:0]      req_addr;
  logic [DW-1:0]      req_wdata;
  logic               rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]      rsp_rdata;
  logic [2*NPINS-1:0] mod_all, sel_all;
  logic [NPINS-1:0]   irqen, irqpol, irqres, intr;
  logic               irq;

  always #5 clk = ~clk;

  gpio_cfg_ctrl #(.NPINS(NPINS), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mod_all   (mod_all),
    .sel_all   (sel_all),
    .irqen     (irqen),
    .irqpol    (irqpol),
    .irqres    (irqres),
    .intr      (intr),
    .irq       (irq)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   res0_cnt = 0, res3_cnt = 0, res_other_cnt = 0;

  // Count cycles each clear-pulse line is high
  always @(negedge clk) begin
    if (irqres[0]) res0_cnt <= res0_cnt + 1;
    if (irqres[3]) res3_cnt <= res3_cnt + 1;
    if ((irqres & ~24'h000009) != '0) res_other_cnt <= res_other_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request; expected response is queued now and popped at the response handshake
  task automatic bus_xfer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp_rdata, input logic exp_err,
                          input logic [NPINS-1:0] intr_set, input int hold);
    exp_t e;
    int   lat;
    bit   ok;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("accept_timeout", 64'(ok), 64'd1);
      req_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    intr      = intr | intr_set;
    lat = 0;
    ok  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("rsp_timeout", 64'(ok), 64'd1);
      void'(exp_q.pop_back());
      return;
    end
    check("rsp_latency", 64'(lat), 64'd2);
    for (int k = 0; k < hold; k++) begin
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      check("hold_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
    check("rsp_err", 64'(rsp_err), 64'(e.err));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int c0, c3;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    intr      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mod_all", 64'(mod_all), 64'd0);
    check("rst_irqres", 64'(irqres), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(req_ready), 64'd1);
    check("rst_sel_all", 64'(sel_all), 64'd0);
    check("rst_irqen", 64'(irqen), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);

    // Pin configuration write/readback
    bus_xfer(1'b1, 6'h05, 32'h0000_000B, 32'h0, 1'b0, '0, 0);
    check("pin5_mod", 64'(mod_all[11:10]), 64'd3);
    check("pin5_sel", 64'(sel_all[11:10]), 64'd2);
    bus_xfer(1'b0, 6'h05, 32'h0, 32'h0000_000B, 1'b0, '0, 0);
    bus_xfer(1'b1, 6'h00, 32'hFFFF_FFFF, 32'h0, 1'b0, '0, 0);
    bus_xfer(1'b0, 6'h00, 32'h0, 32'h0000_000F, 1'b0, '0, 0);
    check("mod_all", 64'(mod_all), 64'h0000_0000_0C03);
    check("sel_all", 64'(sel_all), 64'h0000_0000_0803);
    bus_xfer(1'b1, 6'h19, 32'hFFFF_FFFF, 32'h0, 1'b0, '0, 0);
    bus_xfer(1'b0, 6'h19, 32'h0, 32'h00FF_FFFF, 1'b0, '0, 0);
    check("irqpol", 64'(irqpol), 64'h00FF_FFFF);

    // Out-of-map accesses
    bus_xfer(1'b0, 6'h30, 32'h0, 32'h0, 1'b1, '0, 0);
    bus_xfer(1'b1, 6'h30, 32'hFFFF_FFFF, 32'h0, 1'b1, '0, 0);
    bus_xfer(1'b0, 6'h1C, 32'h0, 32'h0, 1'b1, '0, 0);
    check("err_wr_mod", 64'(mod_all), 64'h0000_0000_0C03);
    check("err_wr_sel", 64'(sel_all), 64'h0000_0000_0803);
    check("err_wr_irqen", 64'(irqen), 64'd0);

    // Interrupt pending, combine and W1C
    bus_xfer(1'b1, 6'h18, 32'h1, 32'h0, 1'b0, '0, 0);
    bus_xfer(1'b1, 6'h1B, 32'h1, 32'h0, 1'b0, '0, 0);
    bus_xfer(1'b0, 6'h1B, 32'h0, 32'h1, 1'b0, '0, 0);
    intr[0] = 1'b1;
    @(negedge clk) check("irq_before_edge", 64'(irq), 64'd0);
    @(negedge clk) check("irq_pend_cycle", 64'(irq), 64'd0);
    @(negedge clk) check("irq_asserted", 64'(irq), 64'd1);
    @(posedge clk); #1;
    bus_xfer(1'b0, 6'h1A, 32'h0, 32'h1, 1'b0, '0, 0);
    c0 = res0_cnt;
    bus_xfer(1'b1, 6'h1A, 32'h1, 32'h0, 1'b0, '0, 0);
    check("irqres0_pulses", 64'(res0_cnt - c0), 64'd1);
    check("irq_cleared", 64'(irq), 64'd0);
    bus_xfer(1'b0, 6'h1A, 32'h0, 32'h0, 1'b0, '0, 0);

    // Set wins over a simultaneous clear
    c3 = res3_cnt;
    bus_xfer(1'b1, 6'h1A, 32'h8, 32'h0, 1'b0, 24'h000008, 0);
    check("irqres3_pulses", 64'(res3_cnt - c3), 64'd1);
    bus_xfer(1'b0, 6'h1A, 32'h0, 32'h8, 1'b0, '0, 0);
    check("irq_masked", 64'(irq), 64'd0);
    bus_xfer(1'b1, 6'h18, 32'h9, 32'h0, 1'b0, '0, 0);
    check("irq_unmasked", 64'(irq), 64'd1);
    bus_xfer(1'b1, 6'h1A, 32'h8, 32'h0, 1'b0, '0, 0);
    bus_xfer(1'b0, 6'h1A, 32'h0, 32'h0, 1'b0, '0, 0);
    check("irq_after_clr3", 64'(irq), 64'd0);
    check("irqres3_total", 64'(res3_cnt - c3), 64'd2);
    check("irqres_other", 64'(res_other_cnt), 64'd0);

    // Response back-pressure
    bus_xfer(1'b0, 6'h19, 32'h0, 32'h00FF_FFFF, 1'b0, '0, 5);

    // Reset during ACCESS drops the transaction
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 6'h01;
    req_wdata = 32'h5;
    @(negedge clk) check("mid_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mid_req_ready", 64'(req_ready), 64'd0);
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("mid_mod_all", 64'(mod_all), 64'd0);
    check("mid_sel_all", 64'(sel_all), 64'd0);
    check("mid_irqen", 64'(irqen), 64'd0);
    check("mid_irqpol", 64'(irqpol), 64'd0);
    check("mid_irq", 64'(irq), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_ready_first", 64'(req_ready), 64'd1);
    check("mid_no_rsp", 64'(rsp_valid), 64'd0);
    // intr[0] and intr[3] are still high; the reset sample of 0 makes them look like fresh edges
    bus_xfer(1'b0, 6'h1A, 32'h0, 32'h9, 1'b0, '0, 0);
    bus_xfer(1'b0, 6'h01, 32'h0, 32'h0, 1'b0, '0, 0);
    bus_xfer(1'b0, 6'h1B, 32'h0, 32'h0, 1'b0, '0, 0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
